// File: rtl/rpn_evaluator_if.sv
// Token, stack and status bundle for rpn_evaluator.
//
// Handshake: a token transfers on a rising clk edge where tok_valid and
// tok_ready are both high. The producer holds tok_is_op/tok_data/tok_last
// stable while tok_valid is high; the evaluator may drop tok_ready at any
// time and never depends on tok_valid to raise it.
// slave  = the evaluator (token consumer, stack controller).
// master = the environment (token source, stack, error clear).
interface rpn_evaluator_if #(
  parameter int WORD_LEN = 8
);
  logic                tok_valid;
  logic                tok_ready;
  logic                tok_is_op;
  logic [WORD_LEN-1:0] tok_data;
  logic                tok_last;
  logic                stk_push;
  logic                stk_pop;
  logic [WORD_LEN-1:0] stk_data_in;
  logic [WORD_LEN-1:0] stk_data_out;
  logic                stk_full;
  logic                stk_empty;
  logic [WORD_LEN-1:0] result;
  logic                result_valid;
  logic                err;
  logic [1:0]          err_code;
  logic                err_clr;

  modport slave (
    input  tok_valid, tok_is_op, tok_data, tok_last,
    input  stk_data_out, stk_full, stk_empty, err_clr,
    output tok_ready, stk_push, stk_pop, stk_data_in,
    output result, result_valid, err, err_code
  );

  modport master (
    output tok_valid, tok_is_op, tok_data, tok_last,
    output stk_data_out, stk_full, stk_empty, err_clr,
    input  tok_ready, stk_push, stk_pop, stk_data_in,
    input  result, result_valid, err, err_code
  );
endinterface

// File: rtl/rpn_evaluator.sv
// Reverse-Polish expression evaluator driving an external stack.
// Operands are pushed; operators pop b (top) then a, push f(a,b); the last
// token triggers a final pop whose value becomes result when the stack is
// left empty. Errors are sticky until err_clr.
// Optional feature macro: RPN_DIV_EN enables opcodes 6 (a/b) and 7 (a%b);
// without it those opcodes are malformed (code 3). Division by zero is
// also malformed.
// The attached stack depth is owned by the stack; only stk_full/stk_empty
// are consulted here.
module rpn_evaluator #(
  parameter int WORD_LEN = 8
) (
  input  logic             clk,
  input  logic             rstn,
  rpn_evaluator_if.slave   bus,
  output logic [3:0]       dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_PUSH_OPND = 4'd1,
    S_POP_B     = 4'd2,
    S_POP_A     = 4'd3,
    S_EXEC      = 4'd4,
    S_PUSH_RES  = 4'd5,
    S_FIN_POP   = 4'd6,
    S_FIN_CAP   = 4'd7,
    S_ERROR     = 4'd8
  } state_t;

  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;
  localparam logic [1:0] ERR_MALF  = 2'd3;

  state_t              state_q, state_d;
  logic [WORD_LEN-1:0] data_q, data_d;
  logic                last_q, last_d;
  logic [WORD_LEN-1:0] b_q, b_d;
  logic [WORD_LEN-1:0] res_q, res_d;
  logic [WORD_LEN-1:0] result_q, result_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0]          code_q, code_d;

  logic                ready_c;
  logic                push_c;
  logic                pop_c;
  logic [WORD_LEN-1:0] din_c;
  logic [WORD_LEN-1:0] a_c;
  logic                legal_c;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      last_q   <= 1'b0;
      b_q      <= '0;
      res_q    <= '0;
      result_q <= '0;
      rvalid_q <= 1'b0;
      code_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      last_q   <= last_d;
      b_q      <= b_d;
      res_q    <= res_d;
      result_q <= result_d;
      rvalid_q <= rvalid_d;
      code_q   <= code_d;
    end
  end

  // Next-state, stack controls and ALU.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    last_d   = last_q;
    b_d      = b_q;
    res_d    = res_q;
    result_d = result_q;
    rvalid_d = 1'b0;
    code_d   = code_q;
    ready_c  = 1'b0;
    push_c   = 1'b0;
    pop_c    = 1'b0;
    din_c    = '0;
    a_c      = bus.stk_data_out;
    legal_c  = 1'b1;

    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.tok_valid) begin
          data_d  = bus.tok_data;
          last_d  = bus.tok_last;
          state_d = bus.tok_is_op ? S_POP_B : S_PUSH_OPND;
        end
      end
      S_PUSH_OPND: begin
        push_c = !bus.stk_full;
        din_c  = data_q;
        if (bus.stk_full) begin
          state_d = S_ERROR;
          code_d  = ERR_OVER;
        end else begin
          state_d = last_q ? S_FIN_POP : S_IDLE;
        end
      end
      S_POP_B: begin
        pop_c = !bus.stk_empty;
        if (bus.stk_empty) begin
          state_d = S_ERROR;
          code_d  = ERR_UNDER;
        end else begin
          state_d = S_POP_A;
        end
      end
      S_POP_A: begin
        // Read data from the POP_B pop is b, the top-of-stack operand.
        b_d   = bus.stk_data_out;
        pop_c = !bus.stk_empty;
        if (bus.stk_empty) begin
          state_d = S_ERROR;
          code_d  = ERR_UNDER;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (data_q[2:0])
          3'd0: res_d = a_c + b_q;
          3'd1: res_d = a_c - b_q;
          3'd2: res_d = a_c * b_q;
          3'd3: res_d = a_c & b_q;
          3'd4: res_d = a_c | b_q;
          3'd5: res_d = a_c ^ b_q;
`ifdef RPN_DIV_EN
          3'd6: begin
            if (b_q == '0) legal_c = 1'b0;
            else           res_d   = a_c / b_q;
          end
          3'd7: begin
            if (b_q == '0) legal_c = 1'b0;
            else           res_d   = a_c % b_q;
          end
`else
          3'd6, 3'd7: legal_c = 1'b0;
`endif
        endcase
        if (legal_c) begin
          state_d = S_PUSH_RES;
        end else begin
          state_d = S_ERROR;
          code_d  = ERR_MALF;
        end
      end
      S_PUSH_RES: begin
        // Two words were just popped, so the stack cannot be full.
        push_c  = 1'b1;
        din_c   = res_q;
        state_d = last_q ? S_FIN_POP : S_IDLE;
      end
      S_FIN_POP: begin
        pop_c = !bus.stk_empty;
        if (bus.stk_empty) begin
          state_d = S_ERROR;
          code_d  = ERR_UNDER;
        end else begin
          state_d = S_FIN_CAP;
        end
      end
      S_FIN_CAP: begin
        if (bus.stk_empty) begin
          result_d = bus.stk_data_out;
          rvalid_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_ERROR;
          code_d  = ERR_MALF;
        end
      end
      S_ERROR: begin
        if (bus.err_clr) begin
          state_d = S_IDLE;
          code_d  = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.tok_ready    = ready_c;
  assign bus.stk_push     = push_c;
  assign bus.stk_pop      = pop_c;
  assign bus.stk_data_in  = din_c;
  assign bus.result       = result_q;
  assign bus.result_valid = rvalid_q;
  assign bus.err          = (state_q == S_ERROR);
  assign bus.err_code     = code_q;
  assign dbg_state_o      = state_q;

endmodule
